shifter_n: RTL and testbench

SHIFTER_N -- requirements
Module: shifter_n

---
 rtl/shifter_n_if.sv | 20 ++
 rtl/shifter_n.sv | 120 ++++++++++++
 tb/tb_shifter_n.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shifter_n_if.sv
// shifter_n_if: operand request / result bus between a producer and shifter_n
interface shifter_n_if #(parameter int W = 64, parameter int DSTW = 4);
  logic ACT, HOLD, CIN;
  logic [W-1:0] A;
  logic [$clog2(W)-1:0] B;
  logic [2:0] SA, OPR;
  logic [DSTW-1:0] DSTi;
  logic [W-1:0] R;
  logic [DSTW-1:0] DSTo;
  logic [2:0] SR;
  logic RDY, BUSY, OVR, ZERO, COUT, SIGN;
  modport master (
    output ACT, HOLD, CIN, A, B, SA, OPR, DSTi,
    input  R, DSTo, SR, RDY, BUSY, OVR, ZERO, COUT, SIGN
  );
  modport slave (
    input  ACT, HOLD, CIN, A, B, SA, OPR, DSTi,
    output R, DSTo, SR, RDY, BUSY, OVR, ZERO, COUT, SIGN
  );
endinterface

// File: rtl/shifter_n.sv
// shifter_n: pipelined shift/rotate unit with stall; RCL/RCR present only with SHIFTER_N_RCX_EN
module shifter_n #(
  parameter int W = 64,
  parameter int DSTW = 4
) (
  input logic CLK,
  input logic RSTN,
  shifter_n_if.slave bus
);
  localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ROL = 3'd2, ROR = 3'd3, ASR = 3'd5;
  localparam logic [8:0] WS = 9'(W);
  logic stall, v1, v2, v3, cin1, c2, o2, s2, c3, o3, s3, z3;
  logic [W-1:0] a1, r2, r3;
  logic [$clog2(W)-1:0] b1;
  logic [2:0] sa1, op1, sa2, sa3;
  logic [DSTW-1:0] d1, d2, d3;
  logic [8:0] sz, n;
  logic [W-1:0] mw, top, am, sh;
  logic [W:0] tx, tl, tr;
  logic msb, fill, co, rsv, cout, ovr, sign;
  assign stall = bus.HOLD & bus.RDY;
  assign bus.BUSY = stall;
`ifdef SHIFTER_N_RCX_EN
  localparam logic [2:0] RCL = 3'd6, RCR = 3'd7;
  logic [W:0] mx, rc, yl, yr;
  assign mx = {1'b0, mw} | tx;
  assign rc = {1'b0, am} | (cin1 ? tx : '0);
  assign yl = ((rc << n) | (rc >> (sz + 9'd1 - n))) & mx;
  assign yr = ((rc >> n) | (rc << (sz + 9'd1 - n))) & mx;
`endif
  // operand geometry: size S, count n, masks marking the S-bit field and its top bit
  always_comb begin
    sz = (sa1 > 3'd4 || (9'd8 << sa1) > WS) ? WS : 9'd8 << sa1;
    n = 9'(b1) & (sz - 9'd1);
    mw = {W{1'b1}} >> (WS - sz);
    top = mw & ~(mw >> 1);
    tx = {top, 1'b0};
    am = a1 & mw;
    msb = |(a1 & top);
    fill = (op1 == ASR) ? msb : cin1;
    tl = ({1'b0, am} << n) | (fill ? ~({(W+1){1'b1}} << n) : '0);
    tr = {am, 1'b0} >> n;
  end
  // shift datapath and flag derivation; n==0 and reserved codes override carry/overflow
  always_comb begin
    sh = '0;
    co = 1'b0;
    rsv = 1'b0;
    case (op1)
      LSL: begin
        sh = tl[W-1:0] & mw;
        co = |(tl & tx);
      end
      LSR, ASR: begin
        sh = tr[W:1] | (fill ? mw & ~(mw >> n) : '0);
        co = tr[0];
      end
      ROL: begin
        sh = ((am << n) | (am >> (sz - n))) & mw;
        co = sh[0];
      end
      ROR: begin
        sh = ((am >> n) | (am << (sz - n))) & mw;
        co = |(sh & top);
      end
`ifdef SHIFTER_N_RCX_EN
      RCL: begin
        sh = yl[W-1:0] & mw;
        co = |(yl & tx);
      end
      RCR: begin
        sh = yr[W-1:0] & mw;
        co = |(yr & tx);
      end
`endif
      default: rsv = 1'b1;
    endcase
    sign = |(sh & top);
    cout = rsv ? 1'b0 : (n == '0 ? cin1 : co);
    ovr = !rsv && n != '0 && (msb ^ sign);
  end
  // capture -> shift -> flags -> output ranks, all frozen while a presented result is held off
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      {v1, v2, v3, cin1, c2, o2, s2, c3, o3, s3, z3} <= '0;
      {a1, r2, r3, b1, sa1, op1, sa2, sa3, d1, d2, d3} <= '0;
      {bus.RDY, bus.R, bus.DSTo, bus.SR, bus.OVR, bus.ZERO, bus.COUT, bus.SIGN} <= '0;
    end else if (!stall) begin
      v1 <= bus.ACT;
      a1 <= bus.A;
      b1 <= bus.B;
      sa1 <= bus.SA;
      op1 <= bus.OPR;
      cin1 <= bus.CIN;
      d1 <= bus.DSTi;
      v2 <= v1;
      r2 <= sh;
      c2 <= cout;
      o2 <= ovr;
      s2 <= sign;
      sa2 <= sa1;
      d2 <= d1;
      v3 <= v2;
      r3 <= r2;
      c3 <= c2;
      o3 <= o2;
      s3 <= s2;
      z3 <= r2 == '0;
      sa3 <= sa2;
      d3 <= d2;
      bus.RDY <= v3;
      bus.R <= r3;
      bus.COUT <= c3;
      bus.OVR <= o3;
      bus.SIGN <= s3;
      bus.ZERO <= z3;
      bus.SR <= sa3;
      bus.DSTo <= d3;
    end
endmodule

// File: tb/tb_shifter_n.sv
// tb_shifter_n: randomized and directed checks of shifter_n against a bit-level reference model
module tb_shifter_n;
  localparam int W = 64, DSTW = 4, BW = $clog2(W);
  typedef struct packed {
    logic v;
    logic [W-1:0] r;
    logic [DSTW-1:0] d;
    logic [2:0] sr;
    logic c, o, z, s;
  } res_t;
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic [DSTW-1:0] tag = '0;
  int checks = 0, errors = 0;
  res_t pipe [4];
  always #5 CLK = ~CLK;
  shifter_n_if #(.W(W), .DSTW(DSTW)) bus ();
  shifter_n #(.W(W), .DSTW(DSTW)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));
  task automatic check(input string t, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", t, got, exp);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] a, input logic [BW-1:0] b, input logic [2:0] sa,
                                 input logic [2:0] op, input logic cin, input logic [DSTW-1:0] d);
    res_t m;
    int s, n;
    logic fill, rsv;
    s = (sa > 3'd4) ? W : (((8 << sa) < W) ? (8 << sa) : W);
    n = int'(b) % s;
    m = '0;
    m.v = 1'b1;
    m.d = d;
    m.sr = sa;
    rsv = 1'b0;
    fill = cin;
    case (op)
      3'd0: begin
        for (int i = 0; i < s; i++) m.r[i] = (i >= n) ? a[i-n] : cin;
        if (n == 0) m.c = cin; else m.c = a[s-n];
      end
      3'd1, 3'd5: begin
        if (op == 3'd5) fill = a[s-1];
        for (int i = 0; i < s; i++) m.r[i] = (i + n < s) ? a[i+n] : fill;
        if (n == 0) m.c = cin; else m.c = a[n-1];
      end
      3'd2: begin
        for (int i = 0; i < s; i++) m.r[i] = a[(i - n + s) % s];
        m.c = (n == 0) ? cin : m.r[0];
      end
      3'd3: begin
        for (int i = 0; i < s; i++) m.r[i] = a[(i + n) % s];
        m.c = (n == 0) ? cin : m.r[s-1];
      end
`ifdef SHIFTER_N_RCX_EN
      3'd6, 3'd7: begin : rcx
        logic [W:0] x, y;
        x = '0;
        y = '0;
        for (int i = 0; i < s; i++) x[i] = a[i];
        x[s] = cin;
        for (int j = 0; j <= s; j++) y[j] = (op == 3'd6) ? x[(j - n + s + 1) % (s + 1)] : x[(j + n) % (s + 1)];
        for (int i = 0; i < s; i++) m.r[i] = y[i];
        m.c = y[s];
      end
`endif
      default: rsv = 1'b1;
    endcase
    m.s = m.r[s-1];
    m.z = (m.r == '0);
    m.o = !rsv && n != 0 && (a[s-1] ^ m.r[s-1]);
    return m;
  endfunction
  task automatic step();
    if (!(bus.HOLD && pipe[3].v)) begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = bus.ACT ? model(bus.A, bus.B, bus.SA, bus.OPR, bus.CIN, bus.DSTi) : '0;
    end
    @(posedge CLK);
    #1;
    check("rdy", bus.RDY, pipe[3].v);
    check("busy", bus.BUSY, bus.HOLD && pipe[3].v);
    if (pipe[3].v) begin
      check("r", bus.R, pipe[3].r);
      check("dst", bus.DSTo, pipe[3].d);
      check("sr", bus.SR, pipe[3].sr);
      check("cout", bus.COUT, pipe[3].c);
      check("ovr", bus.OVR, pipe[3].o);
      check("zero", bus.ZERO, pipe[3].z);
      check("sign", bus.SIGN, pipe[3].s);
    end
  endtask
  task automatic drive(input logic act, input logic hold, input logic [W-1:0] a, input logic [BW-1:0] b,
                       input logic [2:0] sa, input logic [2:0] op, input logic cin);
    bus.ACT = act;
    bus.HOLD = hold;
    bus.A = a;
    bus.B = b;
    bus.SA = sa;
    bus.OPR = op;
    bus.CIN = cin;
    bus.DSTi = tag;
    tag++;
    step();
  endtask
  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 1'b0);
  endtask
  task automatic directed(input string t, input logic [W-1:0] a, input logic [BW-1:0] b, input logic [2:0] sa,
                          input logic [2:0] op, input logic cin, input logic [W-1:0] er,
                          input logic ec, input logic eo, input logic es, input logic ez);
    drive(1'b1, 1'b0, a, b, sa, op, cin);
    idle(3);
    check({t, "_rdy"}, bus.RDY, 1'b1);
    check({t, "_r"}, bus.R, er);
    check({t, "_cout"}, bus.COUT, ec);
    check({t, "_ovr"}, bus.OVR, eo);
    check({t, "_sign"}, bus.SIGN, es);
    check({t, "_zero"}, bus.ZERO, ez);
  endtask
  task automatic check_cleared(input string t);
    check({t, "_rdy"}, bus.RDY, 1'b0);
    check({t, "_busy"}, bus.BUSY, 1'b0);
    check({t, "_r"}, bus.R, '0);
    check({t, "_dst"}, bus.DSTo, '0);
    check({t, "_sr"}, bus.SR, '0);
    check({t, "_flags"}, {bus.OVR, bus.ZERO, bus.COUT, bus.SIGN}, '0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    bus.ACT = 1'b0;
    bus.HOLD = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.SA = '0;
    bus.OPR = '0;
    bus.CIN = 1'b0;
    bus.DSTi = '0;
    #1;
    check_cleared("reset");
    #11 RSTN = 1'b1;
    directed("lsl", 64'h81, 6'd1, 3'd0, 3'd0, 1'b0, 64'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    directed("asr", 64'h8000, 6'd4, 3'd1, 3'd5, 1'b0, 64'hF800, 1'b0, 1'b0, 1'b1, 1'b0);
    directed("ror", 64'h0001, 6'd17, 3'd1, 3'd3, 1'b0, 64'h8000, 1'b1, 1'b1, 1'b1, 1'b0);
    directed("n0", 64'h1A5, 6'd8, 3'd0, 3'd0, 1'b1, 64'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("sa7", 64'h8000_0000_0000_0001, 6'd1, 3'd7, 3'd2, 1'b0, 64'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    directed("rsv", 64'hFF, 6'd3, 3'd0, 3'd4, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SHIFTER_N_RCX_EN
    directed("rcl", 64'h80, 6'd1, 3'd0, 3'd6, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    directed("rcl", 64'h80, 6'd1, 3'd0, 3'd6, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, {$urandom, $urandom}, BW'($urandom), 3'($urandom), 3'd2, 1'b0);
    idle(5);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, {$urandom, $urandom}, BW'($urandom), 3'd3, 3'd0, 1'b1);
    idle(1);
    repeat (3) drive(1'b1, 1'b1, {$urandom, $urandom}, BW'($urandom), 3'd2, 3'd1, 1'b0);
    check("hold_busy", bus.BUSY, 1'b1);
    idle(5);
    drive(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd5, 3'd7, 3'd3, 1'b0);
    repeat (3) drive(1'b0, 1'b1, '0, '0, 3'd0, 3'd0, 1'b0);
    idle(4);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0 + 64'(i), BW'(i + 1), 3'd7, 3'd0, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    check_cleared("rst_async");
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    @(negedge CLK);
    RSTN = 1'b1;
    idle(6);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, {$urandom, $urandom}, BW'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom));
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
